// File: rtl/morphle_wb_cfg.sv
// morphle_wb_cfg
// Wishbone slave that loads configuration words into one Morphle Logic yblock
// and gives the CPU register access to its uin/uout and cbitout signals.
// Configuration words are queued in a FIFO. A timing engine shifts each word
// out on cbitin and follows it with one confclk pulse.
//
// Ports
//   wb_clk_i / wb_rst_i     clock, asynchronous active-low reset
//   wbs_*                   Wishbone slave (classic, single-cycle ack)
//   cell_reset, confclk     yblock reset and configuration clock
//   cbitin / cbitout        configuration bits to / from yblock (cbitout async)
//   uin / uout              user data to / from yblock (uout async)
//
// Register map (word offsets, register index is adr[4:2])
//   0x00 CTRL RW  0x04 STATUS  0x08 CFG_DATA WO  0x0C CBITOUT RO
//   0x10 UIN RW   0x14 UOUT RO 0x18 PULSECNT (any write clears)
module morphle_wb_cfg #(
    parameter int unsigned BLOCKWIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CLKDIV     = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic                    cell_reset,
    output logic                    confclk,
    output logic [BLOCKWIDTH-1:0]   cbitin,
    input  logic [BLOCKWIDTH-1:0]   cbitout,
    output logic [2*BLOCKWIDTH-1:0] uin,
    input  logic [2*BLOCKWIDTH-1:0] uout
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned UW = 2 * BLOCKWIDTH;
    localparam logic [7:0]  DIV_RELOAD = 8'(CLKDIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} state_e;

    // ---------------- bus front end ----------------
    logic        ack_q;
    logic [31:0] dat_q;
    logic        req_we_q;
    logic [2:0]  req_idx_q;
    logic [31:0] req_dat_q;
    logic [3:0]  req_sel_q;

    // register state
    logic                  cell_reset_q, cell_reset_d;
    logic [31:0]           uin_q, uin_d;
    logic                  ovf_q, ovf_d, done_q, done_d;
    logic [15:0]           pcnt_q, pcnt_d;
    logic [BLOCKWIDTH-1:0] cbit_q, cbit_d;
    logic                  confclk_q;
    state_e                state_q, state_d;
    logic [7:0]            div_q, div_d;

    // FIFO
    logic [BLOCKWIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    // synchronizers
    logic [BLOCKWIDTH-1:0] cb_s1_q, cb_s2_q;
    logic [UW-1:0]         uo_s1_q, uo_s2_q;

    logic        hit, acc, wr, push, push_ok, pop, abort, empty, full, busy;
    logic        pcnt_inc, done_set, ovf_set;
    logic [31:0] rd_data;
    logic        unused_ok;

    assign hit   = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    // No new access is accepted while ack is high, so a held strobe is acked every other cycle.
    assign acc   = hit & ~ack_q;
    // The request is latched on acceptance. Its write effect is committed on the ack cycle.
    assign wr    = ack_q & req_we_q;
    assign push  = wr && (req_idx_q == 3'd2);
    assign abort = wr && (req_idx_q == 3'd0) && req_sel_q[0] && req_dat_q[0];
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(FIFO_DEPTH));
    assign busy  = (state_q != S_IDLE);
    assign unused_ok = ^{wbs_adr_i[7:5], wbs_adr_i[1:0]};

    always_comb begin
        rd_data = 32'd0;
        case (wbs_adr_i[4:2])
            3'd0: rd_data = {31'd0, cell_reset_q};
            3'd1: rd_data = {19'd0, 5'(cnt_q), 3'd0, done_q, ovf_q, full, empty, busy};
            3'd3: rd_data = 32'(cb_s2_q);
            3'd4: rd_data = uin_q;
            3'd5: rd_data = 32'(uo_s2_q);
            3'd6: rd_data = {16'd0, pcnt_q};
            default: rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            ack_q     <= 1'b0;
            dat_q     <= 32'd0;
            req_we_q  <= 1'b0;
            req_idx_q <= 3'd0;
            req_dat_q <= 32'd0;
            req_sel_q <= 4'd0;
        end else begin
            ack_q <= acc;
            if (acc) begin
                dat_q     <= rd_data;
                req_we_q  <= wbs_we_i;
                req_idx_q <= wbs_adr_i[4:2];
                req_dat_q <= wbs_dat_i;
                req_sel_q <= wbs_sel_i;
            end
        end
    end

    // ---------------- engine FSM ----------------
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        pop      = 1'b0;
        pcnt_inc = 1'b0;
        done_set = 1'b0;
        case (state_q)
            S_IDLE: if (!empty && !cell_reset_q) begin
                state_d = S_SETUP;
                div_d   = DIV_RELOAD;
                pop     = 1'b1;
            end
            S_SETUP: if (div_q == 8'd0) begin
                state_d  = S_HIGH;
                div_d    = DIV_RELOAD;
                pcnt_inc = 1'b1;
            end else div_d = div_q - 8'd1;
            S_HIGH: if (div_q == 8'd0) begin
                state_d = S_LOW;
                div_d   = DIV_RELOAD;
            end else div_d = div_q - 8'd1;
            S_LOW: if (div_q == 8'd0) begin
                if (!empty) begin
                    state_d = S_SETUP;
                    div_d   = DIV_RELOAD;
                    pop     = 1'b1;
                end else begin
                    state_d  = S_IDLE;
                    done_set = 1'b1;
                end
            end else div_d = div_q - 8'd1;
            default: state_d = S_IDLE;
        endcase
        // Abort: a cell_reset=1 write returns the engine to IDLE without completing the sequence.
        if (abort) begin
            state_d  = S_IDLE;
            pop      = 1'b0;
            pcnt_inc = 1'b0;
            done_set = 1'b0;
        end
    end

    // ---------------- FIFO and register next state ----------------
    always_comb begin
        // If the FIFO is full, a pop in the same cycle frees the slot for the push.
        push_ok  = push && !cell_reset_q && (!full || pop);
        ovf_set  = push && !push_ok;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        cnt_d    = cnt_q + CW'(push_ok) - CW'(pop);
        if (abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
        cbit_d = pop ? mem_q[rd_ptr_q] : cbit_q;

        cell_reset_d = cell_reset_q;
        if (wr && req_idx_q == 3'd0 && req_sel_q[0]) cell_reset_d = req_dat_q[0];

        // W1C clears lose to a set condition in the same cycle.
        ovf_d  = ovf_set  | (ovf_q  & ~(wr && req_idx_q == 3'd1 && req_sel_q[0] && req_dat_q[3]));
        done_d = done_set | (done_q & ~(wr && req_idx_q == 3'd1 && req_sel_q[0] && req_dat_q[4]));

        pcnt_d = pcnt_q;
        if (wr && req_idx_q == 3'd6) pcnt_d = 16'd0;
        else if (pcnt_inc)           pcnt_d = pcnt_q + 16'd1;

        uin_d = uin_q;
        if (wr && req_idx_q == 3'd4)
            for (int b = 0; b < 4; b++)
                if (req_sel_q[b]) uin_d[8*b +: 8] = req_dat_q[8*b +: 8];
    end

    always_ff @(posedge wb_clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= req_dat_q[BLOCKWIDTH-1:0];
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q      <= S_IDLE;
            div_q        <= 8'd0;
            confclk_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            cbit_q       <= '0;
            cell_reset_q <= 1'b1;
            ovf_q        <= 1'b0;
            done_q       <= 1'b0;
            pcnt_q       <= 16'd0;
            uin_q        <= 32'd0;
            cb_s1_q      <= '0;
            cb_s2_q      <= '0;
            uo_s1_q      <= '0;
            uo_s2_q      <= '0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            confclk_q    <= (state_d == S_HIGH);
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            cbit_q       <= cbit_d;
            cell_reset_q <= cell_reset_d;
            ovf_q        <= ovf_d;
            done_q       <= done_d;
            pcnt_q       <= pcnt_d;
            uin_q        <= uin_d;
            cb_s1_q      <= cbitout;
            cb_s2_q      <= cb_s1_q;
            uo_s1_q      <= uout;
            uo_s2_q      <= uo_s1_q;
        end
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_q;
    assign cell_reset = cell_reset_q;
    assign confclk    = confclk_q;
    assign cbitin     = cbit_q;
    assign uin        = uin_q[UW-1:0];

endmodule

// File: tb/tb_morphle_wb_cfg.sv
// Bench for morphle_wb_cfg. Two instances share the bus:
//   dut0 at 0x3000_0000 (CLKDIV=4) and dut1 at 0x3000_0100 (CLKDIV=255, overflow run).
// Bus read data is checked by a scoreboard queue. Pin timing is checked inline.
module tb_morphle_wb_cfg;
    localparam logic [31:0] A0 = 32'h3000_0000;
    localparam logic [31:0] A1 = 32'h3000_0100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        stb = 0, cyc = 0, we = 0;
    logic [3:0]  sel = 0;
    logic [31:0] adr = 0, wdat = 0;

    logic        ack0, ack1, crst0, crst1, cclk0, cclk1;
    logic [31:0] dat0, dat1, uin0, uin1;
    logic [15:0] cbin0, cbin1;
    logic [15:0] cbout0 = 0, cbout1 = 0;
    logic [31:0] uout0 = 0, uout1 = 0;

    morphle_wb_cfg #(.CLKDIV(4), .BASE_ADDR(A0)) dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack0), .wbs_dat_o(dat0), .cell_reset(crst0), .confclk(cclk0),
        .cbitin(cbin0), .cbitout(cbout0), .uin(uin0), .uout(uout0));

    morphle_wb_cfg #(.CLKDIV(255), .BASE_ADDR(A1)) dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack1), .wbs_dat_o(dat1), .cell_reset(crst1), .confclk(cclk1),
        .cbitin(cbin1), .cbitout(cbout1), .uin(uin1), .uout(uout1));

    wire        ack_any = ack0 | ack1;
    wire [31:0] rdat    = ack0 ? dat0 : dat1;

    typedef struct {
        bit          we;
        logic [31:0] exp;
        string       nm;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;
    int  n_cmp = 0, n_bad = 0;
    int  rise0 = 0, rise1 = 0;

    always @(posedge cclk0) rise0++;
    always @(posedge cclk1) rise1++;

    // Monitor: every ack consumes one scoreboard entry, and reads are compared.
    always @(negedge clk) begin
        if (rst_n && ack_any) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_ack: got ack with data %h, want no ack", rdat);
            end else begin
                mon_e = sb.pop_front();
                if (!mon_e.we) begin
                    n_cmp++;
                    if (rdat !== mon_e.exp) begin
                        n_bad++;
                        $display("FAIL %s: got %h want %h", mon_e.nm, rdat, mon_e.exp);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Call at a negedge. Returns at the negedge inside the ack cycle, with the bus released.
    task automatic wb(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] exp, input string nm);
        bit got = 0;
        sb.push_back('{w, exp, nm});
        stb = 1; cyc = 1; we = w; adr = a; wdat = d; sel = s;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ack_any) got = 1;
        end
        stb = 0; cyc = 0; we = 0;
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: got no ack within 20 cycles, want ack", nm);
            void'(sb.pop_back());
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        wb(0, a, 32'd0, 4'hF, exp, nm);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wb(1, a, d, 4'hF, 32'd0, "write");
    endtask

    logic [15:0] w4 [8];
    int base;
    int nack;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // 1. reset state
        chk("rst_cell_reset", 32'(crst0), 1);
        chk("rst_confclk", 32'(cclk0), 0);
        chk("rst_cbitin", 32'(cbin0), 0);
        chk("rst_uin", uin0, 0);
        rd(A0 + 32'h00, 32'h1, "rst_ctrl");
        rd(A0 + 32'h04, 32'h2, "rst_status");
        rd(A0 + 32'h10, 32'h0, "rst_uin_reg");
        rd(A0 + 32'h1C, 32'h0, "unmapped_rd");
        rd(A0 + 32'h08, 32'h0, "wo_cfg_rd");

        // push while cell_reset=1 is dropped and sets ovf; W1C clears it
        wr(A0 + 32'h08, 32'h1234);
        rd(A0 + 32'h04, 32'hA, "ovf_in_reset");
        wr(A0 + 32'h04, 32'h8);
        rd(A0 + 32'h04, 32'h2, "ovf_w1c");

        // 2. single word: confclk rises 6 cycles after the ack cycle
        wr(A0 + 32'h00, 32'h0);
        wr(A0 + 32'h08, 32'hA5A5);
        repeat (5) @(negedge clk);
        chk("t2_clk_low_ack5", 32'(cclk0), 0);
        chk("t2_cbitin", 32'(cbin0), 32'hA5A5);
        @(negedge clk);
        chk("t2_clk_rise_ack6", 32'(cclk0), 1);
        repeat (3) @(negedge clk);
        chk("t2_clk_high_4th", 32'(cclk0), 1);
        @(negedge clk);
        chk("t2_clk_low", 32'(cclk0), 0);
        repeat (4) @(negedge clk);
        rd(A0 + 32'h04, 32'h12, "t2_status_done");
        rd(A0 + 32'h18, 32'h1, "t2_pulsecnt");

        wr(A0 + 32'h04, 32'h10);
        wr(A0 + 32'h18, 32'h0);
        rd(A0 + 32'h18, 32'h0, "pcnt_clear");
        rd(A0 + 32'h04, 32'h2, "done_w1c");

        // 4. abort after third confclk rise
        base = rise0;
        for (int i = 0; i < 8; i++) begin
            w4[i] = 16'h1100 + 16'(i * 17);
            wr(A0 + 32'h08, 32'(w4[i]));
        end
        for (int i = 0; i < 300 && rise0 < base + 3; i++) @(negedge clk);
        chk("t4_three_rises", rise0 - base, 3);
        wr(A0 + 32'h00, 32'h1);
        @(negedge clk);
        chk("t4_confclk_abort", 32'(cclk0), 0);
        chk("t4_cbitin_held", 32'(cbin0), 32'(w4[2]));
        rd(A0 + 32'h04, 32'h2, "t4_status");
        rd(A0 + 32'h18, 32'h3, "t4_pulsecnt");
        chk("t4_cell_reset_pin", 32'(crst0), 1);

        // 5. uin / uout / cbitout
        wr(A0 + 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        chk("t5_uin_pin", uin0, 32'hDEADBEEF);
        uout0 = 32'h12345678;
        cbout0 = 16'h5A3C;
        repeat (3) @(negedge clk);
        rd(A0 + 32'h14, 32'h12345678, "t5_uout");
        rd(A0 + 32'h0C, 32'h5A3C, "t5_cbitout");
        wb(1, A0 + 32'h10, 32'h0, 4'b0001, 32'd0, "write");
        @(negedge clk);
        chk("t5_uin_bytemask", uin0, 32'hDEADBE00);
        rd(A0 + 32'h10, 32'hDEADBE00, "t5_uin_reg");

        // 3. overflow on dut1 (CLKDIV=255): 1 popped + 16 queued, 18th dropped
        wr(A1 + 32'h00, 32'h0);
        for (int i = 0; i < 18; i++) wr(A1 + 32'h08, 32'(i + 1));
        rd(A1 + 32'h04, 32'h100D, "t3_status_full");
        for (int i = 0; i < 20000 && rise1 < 17; i++) @(negedge clk);
        chk("t3_rises", rise1, 17);
        repeat (2 * 255 + 20) @(negedge clk);
        rd(A1 + 32'h18, 32'd17, "t3_pulsecnt");
        rd(A1 + 32'h04, 32'h1A, "t3_status_end");
        chk("t3_last_cbitin", 32'(cbin1), 32'd17);
        wr(A1 + 32'h04, 32'h18);
        rd(A1 + 32'h04, 32'h2, "t6_w1c_both");

        // 6. held strobe: ack 1,0,1
        sb.push_back('{0, 32'h1, "b2b_rd0"});
        sb.push_back('{0, 32'h1, "b2b_rd1"});
        stb = 1; cyc = 1; we = 0; adr = A0; sel = 4'hF;
        @(negedge clk); chk("b2b_ack_1", 32'(ack0), 1);
        @(negedge clk); chk("b2b_ack_0", 32'(ack0), 0);
        @(negedge clk); chk("b2b_ack_2", 32'(ack0), 1);
        stb = 0; cyc = 0;

        // address outside both bases is never acked
        nack = 0;
        stb = 1; cyc = 1; adr = 32'h3000_0200;
        repeat (6) begin
            @(negedge clk);
            if (ack_any) nack++;
        end
        stb = 0; cyc = 0;
        chk("nonhit_ack", nack, 0);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/morphle_wb_cfg.md
Name: morphle_wb_cfg

Overview:
Wishbone slave that configures and exercises one Morphle Logic yblock without LA bit-banging. CPU writes configuration words into a FIFO, and a timing engine shifts them into the block as cbitin/confclk pulses. uin is driven from a register, and the asynchronous uout/cbitout are sampled through 2-flop synchronizers. The block sits between the Wishbone bus and yblock inside user_proj_example.

Parameters:
BLOCKWIDTH, 16, cbitin/cbitout width; uin/uout width is 2*BLOCKWIDTH (max 16).
FIFO_DEPTH, 16, config word FIFO entries (power of 2, >=2).
CLKDIV, 4, wb_clk_i cycles per confclk phase (1..255).
BASE_ADDR, 32'h3000_0000, decoded on wbs_adr_i[31:8].

Ports:
wb_clk_i  in  1  single clock, all logic.
wb_rst_i  in  1  asynchronous, active-low reset.
wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe/cycle/write.
wbs_sel_i  in  4  byte enables.
wbs_adr_i  in  32  address.
wbs_dat_i  in  32  write data.
wbs_ack_o  out  1  acknowledge.
wbs_dat_o  out  32  read data.
cell_reset  out  1  to yblock reset.
confclk  out  1  to yblock confclk.
cbitin  out  BLOCKWIDTH  to yblock cbitin.
cbitout  in  BLOCKWIDTH  from yblock (async).
uin  out  2*BLOCKWIDTH  to yblock uin.
uout  in  2*BLOCKWIDTH  from yblock (async).

Behaviour:
- Reset (wb_rst_i=0): wbs_ack_o=0, wbs_dat_o=0, cell_reset=1, confclk=0, cbitin=0, uin=0. FIFO is empty, FSM is IDLE, all sticky flags and PULSECNT are 0.
- Bus:
  - A hit is valid & adr[31:8]==BASE_ADDR[31:8]; register index is adr[4:2].
  - ack rises the cycle after a hit and lasts exactly 1 cycle. No re-ack while ack=1, so back-to-back strobes get ack every other cycle.
  - A non-hit is never acked.
  - wbs_sel_i byte-masks writes to RW registers. Reads of unmapped or write-only offsets return 0.
- Registers:
  - 0x00 CTRL RW: [0] cell_reset (reset 1).
  - 0x04 STATUS: [0] busy (FSM!=IDLE), [1] empty, [2] full, [3] ovf (sticky, W1C), [4] done (sticky, W1C), [12:8] FIFO level.
  - 0x08 CFG_DATA WO: push wbs_dat_i[BLOCKWIDTH-1:0].
  - 0x0C CBITOUT RO: synchronized cbitout.
  - 0x10 UIN RW: drives uin.
  - 0x14 UOUT RO: synchronized uout, zero-extended.
  - 0x18 PULSECNT: 16-bit count of confclk rising edges; any write clears it; wraps 0xFFFF->0.
- FIFO:
  - A push is committed on the ack cycle.
  - A push when full: the word is dropped, ovf=1, and the bus is still acked.
  - A push while cell_reset=1 is dropped with ovf=1.
- Engine FSM (IDLE, SETUP, HIGH, LOW); each non-IDLE state lasts exactly CLKDIV cycles.
  - IDLE->SETUP when FIFO is non-empty and cell_reset=0. On that transition, pop the head word into cbitin.
  - SETUP->HIGH: confclk=1 during HIGH; PULSECNT increments on entry to HIGH.
  - HIGH->LOW: confclk=0 during LOW.
  - LOW->SETUP (with pop) if FIFO is non-empty. Otherwise LOW->IDLE and done=1.
  - cbitin holds its value until the next pop.
  - First confclk rise is CLKDIV+2 cycles after the ack cycle of a push into an empty FIFO with the FSM IDLE.
- Simultaneous events:
  - A push and a pop in the same cycle when full: the pop wins space and the push is accepted.
  - W1C of a flag in the same cycle its set condition occurs: the flag stays 1.
- Abort:
  - Writing cell_reset=1 while busy forces the FSM to IDLE and confclk=0 on the next cycle.
  - The FIFO is flushed and done is not set; cbitin is unchanged.
- Synchronizers: 2 stages. UOUT/CBITOUT reads reflect input values stable for at least 2 cycles before the hit cycle.

Test Plan:
1. Reset, then read CTRL -> 0x1, STATUS -> 0x2 (empty), UIN -> 0; cell_reset=1, confclk=0.
2. CTRL=0, CLKDIV=4, push 0xA5A5 -> cbitin=0xA5A5 before confclk rises at ack+6. confclk is high 4 cycles and low 4; then done=1, PULSECNT=1.
3. Push 17 words with FIFO_DEPTH=16 and the engine stalled by cell_reset=0 racing -> with cell_reset=1 held, all pushes are dropped and ovf=1. With cell_reset=0 and CLKDIV=255, the 18th back-to-back push sets ovf and PULSECNT ends at 17 (16 queued + 1 popped).
4. Push 8 words, then write CTRL=1 after the 3rd confclk rise -> confclk=0 the next cycle, level=0, busy=0, done=0, PULSECNT=3.
5. UIN=0xDEADBEEF -> uin=0xDEADBEEF. Drive uout=0x12345678 -> UOUT read 3+ cycles later returns 0x12345678; sel=4'b0001 write 0x00 -> uin=0xDEADBE00.
6. Write STATUS 0x18 with done=ovf=1 -> both clear. Bus to an address outside BASE_ADDR -> no ack. Back-to-back strobe -> ack pattern 1,0,1.
